// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 frame receiver.
package ps2_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StData,
      StParity,
      StStop
   } ps2_state_e;

   localparam logic [7:0] PS2_EXT_CODE = 8'hE0;
   localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
   localparam int unsigned PS2_FRAME_BITS = 11;

endpackage

// File: rtl/ps2_rx_frame_if.sv
// Line-side inputs and decoded-byte outputs of the PS/2 receiver.
interface ps2_rx_frame_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] code;
   logic       code_valid;
   logic       parity_err;
   logic       frame_err;
   logic       busy;
   logic       is_break;
   logic       is_ext;

   modport master (
      input  ps2_clk, ps2_data,
      output code, code_valid, parity_err, frame_err, busy, is_break, is_ext
   );

   modport slave (
      output ps2_clk, ps2_data,
      input  code, code_valid, parity_err, frame_err, busy, is_break, is_ext
   );
endinterface

// File: rtl/ps2_edge_filter.sv
// Synchronises the raw PS/2 lines and turns a deglitched clock into a falling-edge strobe.
module ps2_edge_filter #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILTER_LEN  = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic data_sync,
   output logic fall
);
   localparam int unsigned CntW = $clog2(FILTER_LEN + 1);

   logic [SYNC_STAGES-1:0] clk_sync_q;
   // One stage deeper than the clock path to line up with the filter register.
   logic [SYNC_STAGES:0]   data_sync_q;
   logic [CntW-1:0]        cnt_q;
   logic                   filt_q;
   logic                   fall_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync_q  <= '1;
         data_sync_q <= '1;
         cnt_q       <= '0;
         filt_q      <= 1'b1;
         fall_q      <= 1'b0;
      end else begin
         clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
         data_sync_q <= {data_sync_q[SYNC_STAGES-1:0], ps2_data};
         fall_q      <= 1'b0;
         if (clk_sync_q[SYNC_STAGES-1] == filt_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CntW'(FILTER_LEN - 1)) begin
            filt_q <= ~filt_q;
            cnt_q  <= '0;
            fall_q <= filt_q;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign data_sync = data_sync_q[SYNC_STAGES];
   assign fall      = fall_q;

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: deserialise, check parity/stop, time out stalled frames.
// Define PS2_RX_MAKEBREAK_EN to fold E0/F0 prefixes into is_ext/is_break.
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned FILTER_LEN     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 20000
) (
   input logic            clk,
   input logic            reset,
   ps2_rx_frame_if.master bus
);
   localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

   logic            data_sync;
   logic            fall;
   ps2_state_e      state_q, state_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            par_q, par_d;
   logic [TmoW-1:0] tmo_q, tmo_d;
   logic [7:0]      code_q, code_d;
   logic            valid_q, valid_d;
   logic            perr_q, perr_d;
   logic            ferr_q, ferr_d;
   logic            timeout;
`ifdef PS2_RX_MAKEBREAK_EN
   logic            ext_q, ext_d, brk_q, brk_d;
   logic            is_ext_q, is_ext_d, is_brk_q, is_brk_d;
`endif

   ps2_edge_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_LEN (FILTER_LEN)
   ) u_filter (
      .clk      (clk),
      .reset    (reset),
      .ps2_clk  (bus.ps2_clk),
      .ps2_data (bus.ps2_data),
      .data_sync(data_sync),
      .fall     (fall)
   );

   assign timeout = (state_q != StIdle) && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      par_d   = par_q;
      code_d  = code_q;
      valid_d = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      tmo_d   = (state_q == StIdle || fall) ? '0 : tmo_q + 1'b1;
`ifdef PS2_RX_MAKEBREAK_EN
      ext_d    = ext_q;
      brk_d    = brk_q;
      is_ext_d = is_ext_q;
      is_brk_d = is_brk_q;
`endif
      // A fall coinciding with the timeout is processed; the timeout is ignored.
      if (fall) begin
         unique case (state_q)
            StIdle: begin
               if (!data_sync) begin
                  state_d = StData;
                  idx_d   = 3'd0;
               end
            end
            StData: begin
               shift_d[idx_q] = data_sync;
               if (idx_q == 3'd7) state_d = StParity;
               else idx_d = idx_q + 3'd1;
            end
            StParity: begin
               par_d   = data_sync;
               state_d = StStop;
            end
            StStop: begin
               state_d = StIdle;
               if (^{shift_q, par_q} && data_sync) begin
`ifdef PS2_RX_MAKEBREAK_EN
                  if (shift_q == PS2_EXT_CODE) begin
                     ext_d = 1'b1;
                  end else if (shift_q == PS2_BREAK_CODE) begin
                     brk_d = 1'b1;
                  end else begin
                     code_d   = shift_q;
                     valid_d  = 1'b1;
                     is_ext_d = ext_q;
                     is_brk_d = brk_q;
                     ext_d    = 1'b0;
                     brk_d    = 1'b0;
                  end
`else
                  code_d  = shift_q;
                  valid_d = 1'b1;
`endif
               end else if (!(^{shift_q, par_q})) begin
                  perr_d = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end else if (timeout) begin
         state_d = StIdle;
         ferr_d  = 1'b1;
      end
`ifdef PS2_RX_MAKEBREAK_EN
      if (perr_d || ferr_d) begin
         ext_d = 1'b0;
         brk_d = 1'b0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         tmo_q    <= '0;
         code_q   <= 8'h00;
         valid_q  <= 1'b0;
         perr_q   <= 1'b0;
         ferr_q   <= 1'b0;
`ifdef PS2_RX_MAKEBREAK_EN
         ext_q    <= 1'b0;
         brk_q    <= 1'b0;
         is_ext_q <= 1'b0;
         is_brk_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
         tmo_q    <= tmo_d;
         code_q   <= code_d;
         valid_q  <= valid_d;
         perr_q   <= perr_d;
         ferr_q   <= ferr_d;
`ifdef PS2_RX_MAKEBREAK_EN
         ext_q    <= ext_d;
         brk_q    <= brk_d;
         is_ext_q <= is_ext_d;
         is_brk_q <= is_brk_d;
`endif
      end
   end

   assign bus.code       = code_q;
   assign bus.code_valid = valid_q;
   assign bus.parity_err = perr_q;
   assign bus.frame_err  = ferr_q;
   assign bus.busy       = (state_q != StIdle);
`ifdef PS2_RX_MAKEBREAK_EN
   assign bus.is_ext     = is_ext_q;
   assign bus.is_break   = is_brk_q;
`else
   assign bus.is_ext     = 1'b0;
   assign bus.is_break   = 1'b0;
`endif

endmodule

// File: doc/ps2_rx_frame.md
Name: ps2_rx_frame

Overview:
- PS/2 device-to-host frame receiver on the board clock domain.
- Synchronises and deglitches the raw keyboard clock and data lines, deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop), and checks them.
- Emits each scan-code byte with a one-cycle valid strobe.
- Sits directly upstream of the keyboard decoder / ASCII translator that drives the seven-segment and VGA key handling.

Parameters:
- SYNC_STAGES, 2: flip-flop synchroniser depth on ps2_clk and ps2_data (min 2).
- FILTER_LEN, 8: consecutive clk cycles a synchronised ps2_clk level must hold before the filtered clock follows it.
- TIMEOUT_CYCLES, 20000: clk cycles without a filtered falling edge that abort a partial frame (200 us at 100 MHz).

Ports:
- clk  input  1  100 MHz system clock
- reset  input  1  synchronous, active-high reset
- ps2_clk  input  1  raw PS/2 clock line, asynchronous
- ps2_data  input  1  raw PS/2 data line, asynchronous
- code  output  8  last accepted scan-code byte
- code_valid  output  1  one-cycle strobe; code is valid in the same cycle
- parity_err  output  1  one-cycle strobe; frame dropped on parity failure
- frame_err  output  1  one-cycle strobe; bad stop bit or timeout
- busy  output  1  high while a frame is in progress (state != IDLE)
- is_break  output  1  see Optional Feature
- is_ext  output  1  see Optional Feature

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high.
- Reset values:
  - code=8'h00; code_valid, parity_err, frame_err, busy, is_break, is_ext = 0.
  - state=IDLE; filtered clock=1; synchroniser flops=1; timeout counter=0.
- Synchroniser: SYNC_STAGES flops per line.
- Filter:
  - Filtered clock toggles only after the synchronised ps2_clk has differed from it for FILTER_LEN consecutive cycles.
  - Any agreement in between resets the filter count.
- fall: internal one-cycle strobe when the filtered clock goes 1->0.
- Data sampling: synchronised ps2_data is sampled in the fall cycle. Data gets no filter; its extra sync stage matches clock-path timing.
- States and transitions, advancing only on fall:
  - IDLE: sampled bit 0 -> DATA (bit index 0). Sampled bit 1 -> stay in IDLE, no error.
  - DATA: shift sample into shift register at index (LSB first). After index 7 -> PARITY.
  - PARITY: store parity bit -> STOP.
  - STOP: always -> IDLE, then check the frame:
    - if ^{data,parity}==1 and stop==1: code<=data; code_valid=1 in the next cycle.
    - else if parity bad: parity_err=1 in the next cycle. Parity is checked before stop; only one error strobe per frame.
    - else (stop==0): frame_err=1 in the next cycle.
- Latency: code_valid asserts exactly 1 cycle after the fall cycle that samples the stop bit.
- Timeout:
  - Counter clears on every fall and while in IDLE; it increments otherwise.
  - At TIMEOUT_CYCLES-1 in a non-IDLE state: state->IDLE, frame_err pulses the next cycle, and the partial byte is discarded.
  - A fall in the same cycle as the timeout wins: the edge is processed and the counter clears.
- code holds its value between frames. Strobes are never high for more than one cycle.
- Reset mid-frame: state returns to IDLE with no strobes. The remainder of the interrupted frame must be rejected by the start-bit and timeout rules.
- Back-to-back frames: no dead time required beyond the stop edge. A start bit in the cycle after STOP is accepted.

Optional Feature:
- Macro: PS2_RX_MAKEBREAK_EN.
- Defined:
  - Bytes 8'hE0 and 8'hF0 are prefixes. They update internal ext/brk flags and produce no code_valid.
  - The next non-prefix byte raises code_valid with is_ext/is_break reflecting the collected prefixes. Flags clear after that strobe.
  - Any error strobe or reset also clears the flags.
- Not defined: every accepted byte, prefixes included, raises code_valid; is_break and is_ext are tied 0.

Decomposition:
- Package ps2_pkg:
  - state enum (IDLE, DATA, PARITY, STOP).
  - constants PS2_EXT_CODE=8'hE0 and PS2_BREAK_CODE=8'hF0.
  - frame width 11.
- Sub-module ps2_edge_filter:
  - parameters SYNC_STAGES and FILTER_LEN.
  - inputs clk, reset, ps2_clk, ps2_data.
  - outputs data_sync and fall.
- Top holds the FSM, shift register, parity check, timeout and optional prefix logic.

Test Plan:
- Valid frame 0x1C (bits 0,0,0,1,1,1,0,0,0; parity 0; stop 1), 40 us bit period -> one code_valid, code=8'h1C, 1 cycle after the stop fall; no error strobes.
- Same frame with parity bit flipped to 1 -> parity_err for 1 cycle; code unchanged; code_valid never asserted.
- Stop bit driven 0 on a valid 0x29 frame -> frame_err once, busy drops; next valid 0x29 frame -> code_valid, code=8'h29.
- 4 clock edges then silence >TIMEOUT_CYCLES -> frame_err exactly at cycle TIMEOUT_CYCLES after the last fall; busy=0; following frame 0x5A accepted.
- 3-cycle (<FILTER_LEN) low glitches on ps2_clk during IDLE and mid-DATA -> no state advance and no strobes; frame 0x16 still decodes correctly.
- With PS2_RX_MAKEBREAK_EN: sequence E0, F0, 75 -> single code_valid, code=8'h75, is_ext=1, is_break=1. Then 75 alone -> is_ext=0, is_break=0. Without the macro: three code_valid strobes, E0, F0, 75.
